// File: rtl/id_remap_pkg.sv
// Shared constants, types and helpers for the source-to-destination ID remapper.
// No ports; imported by id_inflight_ctr and id_remap_tracker.
package id_remap_pkg;

  localparam int SRC_W_D   = 5;
  localparam int DST_W_D   = 5;
  localparam int NUM_DST_D = 17;
  localparam int CNT_W_D   = 3;

  typedef logic [SRC_W_D-1:0] src_id_t;
  typedef logic [DST_W_D-1:0] dst_id_t;
  typedef logic [CNT_W_D-1:0] cnt_t;

  // Identity map for legal destinations, zero for the rest.
  function automatic int reset_map_entry(
    input int i,
    input int num_dst = NUM_DST_D
  );
    return (i < num_dst) ? i : 0;
  endfunction

endpackage

// File: rtl/id_inflight_ctr.sv
// In-flight counter for one destination ID: saturating up/down.
// Ports: clk, rst, inc, dec in; full, zero, underflow out.
module id_inflight_ctr
  import id_remap_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;
  logic             dec_ok;
  logic             inc_ok;

  assign full      = &cnt;
  assign zero      = (cnt == '0);
  assign underflow = dec && zero;

  // A retire against an empty counter is ignored and flagged.
  assign dec_ok = dec && !zero;
  assign inc_ok = inc && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/id_remap_tracker.sv
// Remaps source IDs to destination IDs and tracks in-flight counts per dest.
// Ports: cfg_* table write, req_* in, out_* translated, rsp_* retire, err.
// Macro ID_REMAP_OUT_REG_EN adds a registered output stage (1-cycle latency).
module id_remap_tracker
  import id_remap_pkg::*;
#(
  parameter int SRC_W   = SRC_W_D,
  parameter int DST_W   = DST_W_D,
  parameter int NUM_DST = NUM_DST_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SRC_W-1:0]   cfg_idx,
  input  logic [DST_W-1:0]   cfg_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SRC_W-1:0]   req_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DST_W-1:0]   out_id,
  output logic [NUM_DST-1:0] out_onehot,
  input  logic               rsp_valid,
  input  logic [DST_W-1:0]   rsp_id,
  output logic               inflight_any,
  output logic               err
);

  localparam int NUM_SRC = 2 ** SRC_W;
  localparam int DST_N   = 2 ** DST_W;
  localparam logic [DST_W:0] NUM_DST_V = NUM_DST[DST_W:0];
  localparam logic [NUM_DST-1:0] ONE = {{(NUM_DST-1){1'b0}}, 1'b1};

  logic [DST_W-1:0]   map_q [NUM_SRC];
  logic [DST_W-1:0]   d;
  logic               stall;
  logic               accept;
  logic [NUM_DST-1:0] inc;
  logic [NUM_DST-1:0] dec;
  logic [NUM_DST-1:0] full;
  logic [NUM_DST-1:0] zero;
  logic [NUM_DST-1:0] uflow;
  logic [DST_N-1:0]   full_ext;
  logic               cfg_bad;
  logic               rsp_bad;

  assign d        = map_q[req_src];
  assign full_ext = DST_N'(full);
  // Stall uses the pre-update count, even with a same-cycle retire.
  assign stall    = full_ext[d];
  assign accept   = req_valid && req_ready;

  assign cfg_bad = cfg_we && ({1'b0, cfg_data} >= NUM_DST_V);
  assign rsp_bad = rsp_valid &&
                   (({1'b0, rsp_id} >= NUM_DST_V) || (|uflow));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        map_q[i] <= DST_W'(reset_map_entry(i, NUM_DST));
      end
    end else if (cfg_we && !cfg_bad) begin
      map_q[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (cfg_bad || rsp_bad) begin
      err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DST; i++) begin : g_ctr
    assign inc[i] = accept && (d == DST_W'(i));
    assign dec[i] = rsp_valid && (rsp_id == DST_W'(i));

    id_inflight_ctr #(
      .CNT_W(CNT_W)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .full     (full[i]),
      .zero     (zero[i]),
      .underflow(uflow[i])
    );
  end

  assign inflight_any = ~&zero;

`ifdef ID_REMAP_OUT_REG_EN
  logic               ov_q;
  logic [DST_W-1:0]   oid_q;
  logic [NUM_DST-1:0] ooh_q;

  assign req_ready  = !stall && (!ov_q || out_ready);
  assign out_valid  = ov_q;
  assign out_id     = oid_q;
  assign out_onehot = ooh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= 1'b0;
      oid_q <= '0;
      ooh_q <= '0;
    end else if (accept) begin
      ov_q  <= 1'b1;
      oid_q <= d;
      ooh_q <= ONE << d;
    end else if (out_ready) begin
      ov_q  <= 1'b0;
    end
  end
`else
  assign req_ready  = out_ready && !stall;
  assign out_valid  = req_valid && !stall;
  assign out_id     = d;
  assign out_onehot = ONE << d;
`endif

endmodule
